// File: rtl/hp_vec_pkg.sv
// hp_vec_pkg: shared constants for the HP vector receiver.
//   - Opcode values carried in DATA[14:11].
//   - Receiver state enumeration.
//   - Default coordinate width.
package hp_vec_pkg;

    localparam int unsigned COORD_W_DEF = 11;

    localparam logic [3:0] OP_SETX  = 4'b0000;
    localparam logic [3:0] OP_MOVEY = 4'b0010;
    localparam logic [3:0] OP_DRAWY = 4'b0011;

    typedef enum logic [2:0] {
        StWaitIdle,
        StReady,
        StHold,
        StExec,
        StEmit
    } state_e;

endpackage

// File: rtl/hp_vector_rx_hs_sync.sv
// hp_hs_sync: two-flop synchronizer for the active-low LDAV handshake line.
// Both flops reset to 1 so a reset never looks like a pending data word.
// Only present when HP_VECTOR_RX_SYNC_EN is defined.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   i_d  - asynchronous input
//   o_q  - synchronized output
`ifdef HP_VECTOR_RX_SYNC_EN
module hp_hs_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`endif

// File: rtl/hp_vector_rx.sv
// hp_vector_rx: receives 15-bit display words over an LDAV/LRFD handshake,
// decodes set-X / move-Y / draw-Y opcodes and emits line vectors with a
// valid/ready interface. Unsupported opcodes bump a saturating error counter.
// Build option:
//   HP_VECTOR_RX_SYNC_EN - pass LDAV through a 2-flop synchronizer (+2 cycles).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   LDAV                - data available from source, active low
//   DATA[14:0]          - [14:11] opcode, [10:0] value
//   LRFD                - ready-for-data to source, active low, registered
//   vec_valid/vec_ready - vector output handshake
//   vec_x0..vec_y1      - vector start and end points
//   err_cnt             - count of unsupported-opcode words
import hp_vec_pkg::*;

module hp_vector_rx #(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               LDAV,
    input  logic [14:0]        DATA,
    output logic               LRFD,
    output logic               vec_valid,
    input  logic               vec_ready,
    output logic [COORD_W-1:0] vec_x0,
    output logic [COORD_W-1:0] vec_y0,
    output logic [COORD_W-1:0] vec_x1,
    output logic [COORD_W-1:0] vec_y1,
    output logic [ERR_W-1:0]   err_cnt
);

    logic               w_ldav;
    logic               w_capture;
    logic [3:0]         w_op;
    logic [COORD_W-1:0] w_value;
    state_e             w_state_nxt;

    state_e             r_state;
    logic               r_lrfd;
    logic [14:0]        r_word;
    logic [COORD_W-1:0] r_cur_x;
    logic [COORD_W-1:0] r_cur_y;
    logic [COORD_W-1:0] r_x_pend;
    logic               r_vec_valid;
    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_y0;
    logic [COORD_W-1:0] r_x1;
    logic [COORD_W-1:0] r_y1;
    logic [ERR_W-1:0]   r_err;

`ifdef HP_VECTOR_RX_SYNC_EN
    hp_hs_sync u_ldav_sync (
        .clk (clk),
        .rst (rst),
        .i_d (LDAV),
        .o_q (w_ldav)
    );
`else
    assign w_ldav = LDAV;
`endif

    assign w_op    = r_word[14:11];
    assign w_value = COORD_W'(r_word[10:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            StWaitIdle: if (w_ldav) w_state_nxt = StReady;
            StReady: begin
                if (!w_ldav) begin
                    w_state_nxt = StHold;
                    w_capture   = 1'b1;
                end
            end
            StHold:  if (w_ldav) w_state_nxt = StExec;
            StExec:  w_state_nxt = (w_op == OP_DRAWY) ? StEmit : StReady;
            // vec_valid is always 1 while in StEmit
            StEmit:  if (vec_ready) w_state_nxt = StReady;
            default: w_state_nxt = StWaitIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StWaitIdle;
            r_lrfd      <= 1'b1;
            r_word      <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_x_pend    <= '0;
            r_vec_valid <= 1'b0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_err       <= '0;
        end else begin
            r_state <= w_state_nxt;
            // LRFD is low only while waiting for a word in StReady
            r_lrfd  <= (w_state_nxt != StReady);
            if (w_capture) r_word <= DATA;

            if (r_state == StExec) begin
                case (w_op)
                    OP_SETX: r_x_pend <= w_value;
                    OP_MOVEY: begin
                        r_cur_x <= r_x_pend;
                        r_cur_y <= w_value;
                    end
                    OP_DRAWY: begin
                        r_x0        <= r_cur_x;
                        r_y0        <= r_cur_y;
                        r_x1        <= r_x_pend;
                        r_y1        <= w_value;
                        r_cur_x     <= r_x_pend;
                        r_cur_y     <= w_value;
                        r_vec_valid <= 1'b1;
                    end
                    default: if (r_err != '1) r_err <= r_err + ERR_W'(1);
                endcase
            end

            if (r_state == StEmit && vec_ready) r_vec_valid <= 1'b0;
        end
    end

    assign LRFD      = r_lrfd;
    assign vec_valid = r_vec_valid;
    assign vec_x0    = r_x0;
    assign vec_y0    = r_y0;
    assign vec_x1    = r_x1;
    assign vec_y1    = r_y1;
    assign err_cnt   = r_err;

endmodule

// File: tb/tb_hp_vector_rx.sv
// tb_hp_vector_rx: directed self-checking bench for hp_vector_rx.
// A word-level model (set-X / move-Y / draw-Y arithmetic and an expected
// vector queue) predicts every emitted vector; a compare process checks the
// vector outputs whenever vec_valid is high. Literal checks pin the model.
module tb_hp_vector_rx;

    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] y0;
        logic [10:0] x1;
        logic [10:0] y1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        LDAV;
    logic [14:0] DATA;
    logic        LRFD;
    logic        vec_valid;
    logic        vec_ready;
    logic [10:0] vec_x0;
    logic [10:0] vec_y0;
    logic [10:0] vec_x1;
    logic [10:0] vec_y1;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_vec    = 0;
    vec_t got_vec;

    // word-level model
    vec_t        exp_q[$];
    logic [10:0] m_xp;
    logic [10:0] m_cx;
    logic [10:0] m_cy;
    int          m_err;

    hp_vector_rx dut (
        .clk       (clk),
        .rst       (rst),
        .LDAV      (LDAV),
        .DATA      (DATA),
        .LRFD      (LRFD),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_x0    (vec_x0),
        .vec_y0    (vec_y0),
        .vec_x1    (vec_x1),
        .vec_y1    (vec_y1),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout, expected handshake event", name);
    endtask

    task automatic model_reset();
        m_xp  = '0;
        m_cx  = '0;
        m_cy  = '0;
        m_err = 0;
        exp_q.delete();
    endtask

    task automatic model_word(input logic [14:0] w);
        logic [3:0]  op;
        logic [10:0] v;
        op = w[14:11];
        v  = w[10:0];
        if (op == 4'd0) begin
            m_xp = v;
        end else if (op == 4'd2) begin
            m_cx = m_xp;
            m_cy = v;
        end else if (op == 4'd3) begin
            exp_q.push_back('{x0: m_cx, y0: m_cy, x1: m_xp, y1: v});
            m_cx = m_xp;
            m_cy = v;
        end else if (m_err < 255) begin
            m_err++;
        end
    endtask

    task automatic wait_lrfd(input logic lvl, input string name);
        int n = 0;
        while (LRFD !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (LRFD !== lvl) timeout(name);
    endtask

    task automatic send_word(input logic [14:0] w);
        wait_lrfd(1'b0, "lrfd_low_wait");
        DATA = w;
        LDAV = 1'b0;
        model_word(w);
        @(negedge clk);
        wait_lrfd(1'b1, "lrfd_high_wait");
        LDAV = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(LRFD === 1'b0 && vec_valid === 1'b0 && exp_q.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout(name);
    endtask

    task automatic check_got(input string name, input int x0, input int y0,
                             input int x1, input int y1);
        check({name, "_x0"}, 32'(got_vec.x0), x0);
        check({name, "_y0"}, 32'(got_vec.y0), y0);
        check({name, "_x1"}, 32'(got_vec.x1), x1);
        check({name, "_y1"}, 32'(got_vec.y1), y1);
    endtask

    // Compare process: sampled 1 time unit after the falling edge, when the
    // bench inputs for the next rising edge are already settled.
    always begin
        @(negedge clk);
        #1;
        if (rst === 1'b0 && vec_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_vector", 32'(vec_valid), 0);
            end else begin
                check("vec_x0", 32'(vec_x0), 32'(exp_q[0].x0));
                check("vec_y0", 32'(vec_y0), 32'(exp_q[0].y0));
                check("vec_x1", 32'(vec_x1), 32'(exp_q[0].x1));
                check("vec_y1", 32'(vec_y1), 32'(exp_q[0].y1));
                check("lrfd_in_emit", 32'(LRFD), 1);
                if (vec_ready === 1'b1) begin
                    got_vec = '{x0: vec_x0, y0: vec_y0, x1: vec_x1, y1: vec_y1};
                    void'(exp_q.pop_front());
                    n_vec++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        // stale start: LDAV already low when reset releases
        rst       = 1'b1;
        LDAV      = 1'b0;
        DATA      = 15'h19F4;
        vec_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_lrfd", 32'(LRFD), 1);
        check("rst_vec_valid", 32'(vec_valid), 0);
        check("rst_vec_x0", 32'(vec_x0), 0);
        check("rst_vec_y1", 32'(vec_y1), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stale_lrfd", 32'(LRFD), 1);
        end
        LDAV = 1'b1;

        // basic draw
        send_word(15'h0000);
        send_word(15'h1000);
        send_word(15'h01F4);
        send_word(15'h19F4);
        wait_idle("basic_idle");
        check("basic_nvec", n_vec, 1);
        check_got("basic", 0, 0, 500, 500);
        check("basic_err", 32'(err_cnt), 0);

        // backpressure
        vec_ready = 1'b0;
        send_word(15'h0064);
        send_word(15'h18C8);
        n = 0;
        while (vec_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (vec_valid !== 1'b1) timeout("bp_valid_wait");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(vec_valid), 1);
            check("bp_lrfd_held", 32'(LRFD), 1);
        end
        vec_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 32'(vec_valid), 0);
        check("bp_lrfd_ready", 32'(LRFD), 0);
        check("bp_nvec", n_vec, 2);
        check_got("bp", 500, 500, 100, 200);

        // set-X words without a Y word leave the current point alone
        send_word(15'h0123);
        send_word(15'h0045);
        send_word(15'h1811);
        wait_idle("setx_idle");
        check_got("setx_only", 100, 200, 69, 17);

        // unsupported opcode and saturation
        send_word(15'h3800);
        wait_idle("err1_idle");
        check("err_one", 32'(err_cnt), 1);
        check("err_nvec", n_vec, 3);
        for (int i = 0; i < 300; i++) send_word(15'h3800);
        wait_idle("err_sat_idle");
        check("err_sat", 32'(err_cnt), 255);
        check("err_model", 32'(err_cnt), m_err);

        // full-scale coordinate values
        send_word(15'h07FF);
        send_word(15'h17FF);
        send_word(15'h0000);
        send_word(15'h1800);
        wait_idle("wrap_idle");
        check_got("wrap", 2047, 2047, 0, 0);

        // reset while holding a draw word
        wait_lrfd(1'b0, "hold_lrfd_low");
        DATA = 15'h19F4;
        LDAV = 1'b0;
        @(negedge clk);
        wait_lrfd(1'b1, "hold_lrfd_high");
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("hold_rst_lrfd", 32'(LRFD), 1);
        check("hold_rst_valid", 32'(vec_valid), 0);
        check("hold_rst_x1", 32'(vec_x1), 0);
        check("hold_rst_err", 32'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_stale_lrfd", 32'(LRFD), 1);
        end
        LDAV = 1'b1;
        send_word(15'h0003);
        send_word(15'h1804);
        wait_idle("post_rst_idle1");
        check("post_rst_nvec", n_vec, 5);
        check_got("post_rst_draw", 0, 0, 3, 4);
        send_word(15'h000A);
        send_word(15'h1014);
        send_word(15'h001E);
        send_word(15'h1828);
        wait_idle("post_rst_idle2");
        check_got("post_rst_move_draw", 10, 20, 30, 40);
        check("post_rst_err", 32'(err_cnt), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hp_vector_rx.md
HP_VECTOR_RX -- requirements
Module: hp_vector_rx

Interface
REQ-001 Parameter COORD_W, default 11, width of each coordinate field.
REQ-002 Parameter ERR_W, default 8, width of the saturating error counter.
REQ-003 clk  input  1  single clock; all logic rises on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 LDAV  input  1  data-available from the display source, active low.
REQ-006 DATA  input  15  source word: [14:11] opcode, [10:0] value.
REQ-007 LRFD  output  1  ready-for-data to the source, active low, registered.
REQ-008 vec_valid  output  1  vector command available.
REQ-009 vec_ready  input  1  downstream line drawer accepts the vector.
REQ-010 vec_x0, vec_y0, vec_x1, vec_y1  output  COORD_W each  vector start and end points.
REQ-011 err_cnt  output  ERR_W  count of words with unsupported opcodes.

Function
REQ-012 The block SHALL implement the following states: WAIT_IDLE, READY, HOLD, EXEC and EMIT.
REQ-013 WAIT_IDLE: LRFD=1; go to READY on the first cycle LDAV=1 is sampled.
REQ-014 READY: LRFD=0; when LDAV=0 is sampled, capture DATA into the word register, drive LRFD=1 from the next cycle and go to HOLD.
REQ-015 HOLD: LRFD=1; stay until LDAV=1 is sampled, then go to EXEC. LRFD SHALL NOT return to 0 before LDAV=1 is observed.
REQ-016 EXEC (one cycle, LRFD=1): decode the captured word.
  - 0000: x_pend <= value.
  - 0010 (move): cur_x <= x_pend, cur_y <= value; next state READY.
  - 0011 (draw): vec_x0/y0 <= cur_x/cur_y, vec_x1 <= x_pend, vec_y1 <= value, cur_x/cur_y <= x_pend/value, vec_valid <= 1; next state EMIT.
  - Any other opcode: err_cnt increments, no other state changes; next state READY.
REQ-017 EMIT: LRFD=1; vec_valid and all vec_* outputs SHALL remain stable until the cycle vec_valid and vec_ready are both 1; vec_valid=0 on the following cycle, then READY.
REQ-018 Backpressure: while in EMIT, no new word SHALL be accepted (LRFD held 1).
REQ-019 Latency: LDAV=0 sampled at edge N yields LRFD=1 after edge N; LDAV=1 sampled at edge M yields vec_valid=1 after edge M+1 for a draw word.
REQ-020 Coordinates are unsigned COORD_W bits, stored without clipping or arithmetic; value 2047 passes unchanged.
REQ-021 err_cnt SHALL saturate at all-ones.
REQ-022 An opcode 0000 word not followed by a Y word leaves cur_x/cur_y unchanged.

Reset
REQ-023 On rst: state=WAIT_IDLE, LRFD=1, vec_valid=0, all vec_* outputs=0, cur_x/cur_y/x_pend=0, err_cnt=0.
REQ-024 Reset asserted in any state, including HOLD or EMIT, SHALL discard the pending word or vector; after release, the handshake restarts from WAIT_IDLE.

Configuration
REQ-025 Macro HP_VECTOR_RX_SYNC_EN defined: LDAV SHALL pass through a 2-flop synchronizer, with DATA captured on the synchronized falling edge; all LDAV-relative latencies increase by 2 cycles.
REQ-026 Macro not defined: LDAV SHALL be used directly, with the latencies stated in REQ-019.

Structure
REQ-027 Package hp_vec_pkg SHALL hold the opcode constants (OP_SETX, OP_MOVEY, OP_DRAWY), the state enumeration and the default COORD_W.
REQ-028 Sub-module hp_hs_sync (2-flop synchronizer with async reset to 1) SHALL be instantiated only under HP_VECTOR_RX_SYNC_EN.

Verification
REQ-029 Basic draw: send words 0x0000, 0x1000, 0x01F4, 0x19F4 with vec_ready=1 -> exactly one vector (0,0)->(500,500); err_cnt=0.
REQ-030 Backpressure: hold vec_ready=0 for 20 cycles after a draw -> vec_* stable, LRFD=1 throughout; the next word is accepted only after the ready pulse.
REQ-031 Unsupported opcode: send word 0x3800 (opcode 0111) -> no vector, err_cnt=1; 300 such words -> err_cnt=255.
REQ-032 Stale start: LDAV=0 at reset release -> no capture and LRFD=1 until LDAV=1 is seen, then the normal handshake resumes.
REQ-033 Reset mid-HOLD after word 0x19F4 -> no vector emitted; a subsequent move and draw behaves as from reset.
REQ-034 Wrap value: send 0x07FF, 0x17FF, 0x0000, 0x1800 -> vector (2047,2047)->(0,0).
